tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter: W, default 4, data bits per slot (legal 1..16).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  sample enable; low freezes all state.
REQ-005 SHALL have port: fsync  input  1  frame start; marks the cycle carrying the first bit of slot 0.
REQ-006 SHALL have port: din  input  1  shared serial line, MSB first per slot.
REQ-007 SHALL have port: dout  output  4*W  channel registers; slot k at bits [k*W +: W].
REQ-008 SHALL have port: valid  output  4  one-hot, one-cycle pulse per slot update.
REQ-009 SHALL have port: busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port: err  output  4  per-slot parity error pulse (present only with TDM_DEMUX4_PARITY_EN).

Function
REQ-011 SHALL implement states IDLE and RUN; IDLE->RUN on en&fsync; RUN->IDLE after the last bit of slot 3.
REQ-012 SHALL sample din only when en=1; en=0 holds state, slot index, bit count and shift register; fsync with en=0 is ignored.
REQ-013 SHALL treat the din bit in the en&fsync cycle as bit 0 (MSB) of slot 0.
REQ-014 SHALL use a 2-bit slot index and a bit counter sized for slot length L (L=W, or W+1 with parity).
REQ-015 SHALL, on the L-th sampled bit of slot k, load dout[k] on the next clock edge and pulse valid[k] for exactly that one cycle; latency 1 cycle after last bit.
REQ-016 SHALL leave dout slots not being written unchanged.
REQ-017 SHALL advance slot index k->k+1 with no gap cycle; the next slot's first bit may be sampled in the cycle after slot k's last bit.
REQ-018 SHALL, on en&fsync while RUN, discard the partial slot (no dout/valid update), restart at slot 0 bit 0 with that cycle's din.
REQ-019 SHALL, when en&fsync coincides with the last bit of slot 3, complete slot 3 (valid[3] pulse) and start a new frame at slot 0 in that same cycle.
REQ-020 SHALL drive busy=1 in RUN, 0 in IDLE; din ignored in IDLE without fsync.

Reset
REQ-021 SHALL, on rst_n low (asynchronous), force state IDLE, dout=0, valid=0, busy=0, err=0, counters and shift register 0.
REQ-022 SHALL abandon any frame in progress on reset; first post-reset slot update requires a new fsync.

Configuration
REQ-023 SHALL, with macro TDM_DEMUX4_PARITY_EN defined, use L=W+1: W data bits then one even-parity bit over the data.
REQ-024 SHALL, with parity enabled and mismatch on slot k, leave dout[k] unchanged, suppress valid[k], and pulse err[k] for one cycle (same timing as valid).
REQ-025 SHALL, without the macro, use L=W and omit port err and all parity logic.

Structure
REQ-026 SHALL place the state enum (IDLE, RUN), slot count constant 4 and default W in shared package tdm_demux_pkg.
REQ-027 SHALL use one sub-module slot_dec2_4 converting slot index plus a strobe into the one-hot write/valid vector.

Verification
REQ-028 SHALL cover nominal frame: W=4, fsync then bits 1010,0011,1111,0000 -> dout=16'h0F3A, valid pulses 0001,0010,0100,1000 one cycle after each slot's 4th bit, busy low after.
REQ-029 SHALL cover en gating: same frame with en=0 for 3 cycles mid-slot 1 -> identical dout, valid[1] delayed by 3 cycles.
REQ-030 SHALL cover resync: fsync at bit 2 of slot 2 then full frame 0001,0010,0100,1000 -> no valid[2] from aborted slot, final dout=16'h8421.
REQ-031 SHALL cover back-to-back frames: fsync on slot 3 last bit -> valid[3] and new frame slot 0 with no lost bit.
REQ-032 SHALL cover async reset mid-slot 1 -> all outputs 0 immediately, no valid until next fsync frame.
REQ-033 SHALL cover parity (macro on): slot 1 data 0011 parity 1 -> err=0010 pulse, dout[1] unchanged, valid[1] absent; others update.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NSLOT = 4;  // slots per frame
  localparam int W_DEF = 4;  // default data bits per slot

endpackage

// File: rtl/slot_dec2_4.sv
// Slot index to one-hot decoder, gated by a strobe.
// Latency: combinational.
// Backpressure: none.
// Ports: idx - slot index; stb - qualify; onehot - one bit per slot, all zero when stb=0.
module slot_dec2_4
  import tdm_demux_pkg::*;
(
  input  logic [1:0]       idx,
  input  logic             stb,
  output logic [NSLOT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (stb) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot serial TDM demultiplexer: shifts din MSB-first into per-slot channel registers.
// Latency: dout[k]/valid[k] update on the clock edge that samples slot k's last bit.
// Backpressure: none; en=0 freezes all state, otherwise one bit is taken per cycle.
// Ports: clk, rst_n (async, active-low), en, fsync (first bit of slot 0), din,
//        dout (slot k at [k*W +: W]), valid (one-hot pulse), busy (frame in progress),
//        err (per-slot parity error pulse, only with TDM_DEMUX4_PARITY_EN).
// Build option: define TDM_DEMUX4_PARITY_EN to append one even-parity bit per slot.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               fsync,
  input  logic               din,
  output logic [NSLOT*W-1:0] dout,
  output logic [NSLOT-1:0]   valid,
  output logic               busy
`ifdef TDM_DEMUX4_PARITY_EN
  ,
  output logic [NSLOT-1:0]   err
`endif
);

`ifdef TDM_DEMUX4_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  // Only L-1 bits of history are needed; the current din completes the word.
  localparam int SW = (L > 1) ? L - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  state_t        state_q, state_n;
  logic [1:0]    slot_q, slot_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [SW-1:0] sh_q, sh_n;

  logic          smp, wrap, cmpl;
  logic [1:0]    pos_slot, cmpl_slot;
  logic [CW-1:0] pos_cnt;
  logic [L-1:0]  old_word, new_word, cmpl_word;
  logic [W-1:0]  data;
  logic [NSLOT-1:0] hot, wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    slot_n    = slot_q;
    cnt_n     = cnt_q;
    sh_n      = sh_q;
    smp       = en & ((state_q == RUN) | fsync);
    // fsync overrides the running position: this cycle's bit is slot 0, bit 0.
    pos_slot  = fsync ? 2'd0 : slot_q;
    pos_cnt   = fsync ? '0 : cnt_q;
    // fsync landing on slot 3's last bit still completes slot 3 with this din,
    // which also serves as the new frame's first bit. Any other in-frame fsync
    // drops the partial slot. With L=1 the slot-3 completion takes precedence.
    wrap      = en & fsync & (state_q == RUN) & (slot_q == 2'd3) & (cnt_q == LAST);
    old_word  = L'({sh_q, din});
    new_word  = fsync ? L'(din) : old_word;
    cmpl      = smp & (wrap | (pos_cnt == LAST));
    cmpl_slot = wrap ? 2'd3 : pos_slot;
    cmpl_word = wrap ? old_word : new_word;

    if (smp) begin
      sh_n = SW'(new_word);
      if (pos_cnt == LAST) begin
        cnt_n = '0;
        if (pos_slot == 2'd3) begin
          state_n = IDLE;
          slot_n  = 2'd0;
        end else begin
          state_n = RUN;
          slot_n  = pos_slot + 2'd1;
        end
      end else begin
        state_n = RUN;
        slot_n  = pos_slot;
        cnt_n   = pos_cnt + CW'(1);
      end
    end
  end

  assign data = cmpl_word[L-1 -: W];

  slot_dec2_4 u_dec (
    .idx   (cmpl_slot),
    .stb   (cmpl),
    .onehot(hot)
  );

`ifdef TDM_DEMUX4_PARITY_EN
  logic par_ok;
  assign par_ok = ~^cmpl_word;  // data plus parity bit must XOR to zero
  assign wr     = hot & {NSLOT{par_ok}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= '0;
    else        err <= hot & {NSLOT{~par_ok}};
  end
`else
  assign wr = hot;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= '0;
    end else begin
      valid <= wr;
      for (int k = 0; k < NSLOT; k++) begin
        if (wr[k]) dout[k*W +: W] <= data;
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (W=4); covers TDM_DEMUX4_PARITY_EN when defined.
// Latency: n/a.
// Backpressure: n/a.
module tb_tdm_demux4;
  import tdm_demux_pkg::*;

  localparam int W = 4;
`ifdef TDM_DEMUX4_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic           clk = 1'b0;
  logic           rst_n, en, fsync, din;
  logic [4*W-1:0] dout;
  logic [3:0]     valid;
  logic           busy;
  logic [3:0]     errs;
`ifdef TDM_DEMUX4_PARITY_EN
  logic [3:0]     err;
  assign errs = err;
`else
  assign errs = 4'b0;
`endif

  always #5 clk = ~clk;

  tdm_demux4 #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .fsync(fsync),
    .din  (din),
    .dout (dout),
    .valid(valid),
    .busy (busy)
`ifdef TDM_DEMUX4_PARITY_EN
    ,
    .err  (err)
`endif
  );

  typedef struct {
    int           cyc;
    logic [3:0]   v;
    logic [3:0]   e;
    logic [W-1:0] d;
  } exp_t;

  exp_t           q[$];
  exp_t           xm;
  logic [4*W-1:0] mdl;
  int             n_vec = 0;
  int             n_bad = 0;
  int             cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Slot word as sent on the line: data MSB first, then even parity when enabled.
  function automatic logic [L-1:0] mkword(input logic [W-1:0] d, input logic bad);
    logic [W:0] t;
    t = {d, (^d) ^ bad};
    return t[W -: L];
  endfunction

  // Monitor: every pulse must match the oldest scoreboard entry, including its cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if ((valid | errs) != 4'b0) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", {24'b0, valid, errs}, 32'h0);
      end else begin
        xm = q.pop_front();
        chk("pulse_cycle", cyc, xm.cyc);
        chk("valid", {28'b0, valid}, {28'b0, xm.v});
`ifdef TDM_DEMUX4_PARITY_EN
        chk("err", {28'b0, errs}, {28'b0, xm.e});
`endif
        for (int k = 0; k < 4; k++)
          if (xm.v[k]) mdl[k*W +: W] = xm.d;
        chk("dout_model", {16'b0, dout}, {16'b0, mdl});
      end
    end
  end

  task automatic drive(input logic e, input logic f, input logic d);
    @(negedge clk);
    en = e; fsync = f; din = d;
  endtask

  // Called right after the driving negedge: the sampling edge is cycle cyc+1.
  task automatic push(input int slot, input logic [W-1:0] d, input logic bad);
    exp_t x;
    x.cyc = cyc + 1;
    x.v   = bad ? 4'b0 : (4'b1 << slot);
    x.e   = bad ? (4'b1 << slot) : 4'b0;
    x.d   = d;
    q.push_back(x);
  endtask

  // Sends bits [from, to) of a slot; fsync on bit 0 when first is set.
  task automatic send_slot(input int slot, input logic [W-1:0] d, input logic first,
                           input logic bad, input int from, input int to);
    logic [L-1:0] w;
    w = mkword(d, bad);
    for (int i = from; i < to; i++) begin
      drive(1'b1, first && (i == 0), w[L-1-i]);
      if (i == L - 1) push(slot, d, bad);
    end
  endtask

  task automatic send_frame(input logic [4*W-1:0] f, input logic [3:0] bad);
    for (int k = 0; k < 4; k++)
      send_slot(k, f[k*W +: W], k == 0, bad[k], 0, L);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  logic [L-1:0] w3;
  logic [W-1:0] n0;

  initial begin
    rst_n = 1'b0; en = 1'b0; fsync = 1'b0; din = 1'b0; mdl = '0;
    #12;
    chk("rst_dout", {16'b0, dout}, 32'h0);
    chk("rst_valid", {28'b0, valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
`ifdef TDM_DEMUX4_PARITY_EN
    chk("rst_err", {28'b0, errs}, 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // din without fsync in IDLE is ignored
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // nominal frame
    send_slot(0, 4'hA, 1'b1, 1'b0, 0, L);
    chk("busy_run", {31'b0, busy}, 32'h1);
    send_slot(1, 4'h3, 1'b0, 1'b0, 0, L);
    send_slot(2, 4'hF, 1'b0, 1'b0, 0, L);
    send_slot(3, 4'h0, 1'b0, 1'b0, 0, L);
    idle(2);
    chk("nominal_busy", {31'b0, busy}, 32'h0);
    chk("nominal_dout", {16'b0, dout}, 32'h0F3A);

    // resync at bit 2 of slot 2: partial slot 2 never lands
    send_slot(0, 4'h1, 1'b1, 1'b0, 0, L);
    send_slot(1, 4'h2, 1'b0, 1'b0, 0, L);
    send_slot(2, 4'h5, 1'b0, 1'b0, 0, 2);
    send_frame(16'h8421, 4'b0);
    idle(2);
    chk("resync_dout", {16'b0, dout}, 32'h8421);

    // en gating mid slot 1; fsync during en=0 must be ignored
    send_slot(0, 4'hA, 1'b1, 1'b0, 0, L);
    send_slot(1, 4'h3, 1'b0, 1'b0, 0, 2);
    drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b0, 1'b0); drive(1'b0, 1'b1, 1'b1);
    send_slot(1, 4'h3, 1'b0, 1'b0, 2, L);
    send_slot(2, 4'hF, 1'b0, 1'b0, 0, L);
    send_slot(3, 4'h0, 1'b0, 1'b0, 0, L);
    idle(2);
    chk("engate_dout", {16'b0, dout}, 32'h0F3A);

    // fsync on slot 3's last bit: that bit completes slot 3 and opens the new frame
    send_slot(0, 4'h5, 1'b1, 1'b0, 0, L);
    send_slot(1, 4'h6, 1'b0, 1'b0, 0, L);
    send_slot(2, 4'h7, 1'b0, 1'b0, 0, L);
    w3 = mkword(4'h9, 1'b0);
    send_slot(3, 4'h9, 1'b0, 1'b0, 0, L - 1);
    drive(1'b1, 1'b1, w3[0]);
    push(3, 4'h9, 1'b0);
    n0 = {w3[0], 3'b101};
    send_slot(0, n0, 1'b0, 1'b0, 1, L);
    chk("wrap_busy", {31'b0, busy}, 32'h1);
    send_slot(1, 4'hB, 1'b0, 1'b0, 0, L);
    send_slot(2, 4'hC, 1'b0, 1'b0, 0, L);
    send_slot(3, 4'hD, 1'b0, 1'b0, 0, L);
    // next frames with fsync right after the last bit, no gap
    send_frame(16'h1234, 4'b0);
    send_frame(16'h5678, 4'b0);
    idle(2);
    chk("b2b_dout", {16'b0, dout}, 32'h5678);

    // async reset mid slot 1
    send_slot(0, 4'h9, 1'b1, 1'b0, 0, L);
    send_slot(1, 4'h6, 1'b0, 1'b0, 0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", {16'b0, dout}, 32'h0);
    chk("arst_valid", {28'b0, valid}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    mdl = '0;
    @(negedge clk) rst_n = 1'b1; en = 1'b1; fsync = 1'b0;
    idle(6);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_dout", {16'b0, dout}, 32'h0);
    send_frame(16'hC3A5, 4'b0);
    idle(2);
    chk("post_rst_frame", {16'b0, dout}, 32'hC3A5);

`ifdef TDM_DEMUX4_PARITY_EN
    // bad parity on slot 1: err pulse, slot 1 keeps its old value
    send_frame(16'h0F3A, 4'b0010);
    idle(2);
    chk("parity_dout", {16'b0, dout}, 32'h0FAA);
`endif

    idle(3);
    chk("queue_empty", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
